// File: rtl/fre_div_pkg.sv
// fre_div_pkg: shared state encoding, ratio floor and duty helper for the divider controller
package fre_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} state_t;
  localparam int MIN_DIV = 2;
  function automatic int unsigned high_time(input int unsigned n);
    return n - n / 2;
  endfunction
endpackage

// File: rtl/fre_div_cnt.sv
// fre_div_cnt: period counter with registered boundary flag and duty compare
module fre_div_cnt import fre_div_pkg::*; #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic [DIV_W-1:0] cnt,
  output logic             last,
  output logic             hi
);
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, r_hi;
  assign w_cnt_nxt = (!run || restart || r_last) ? '0 : r_cnt + 1'b1;
  // run/div describe the coming cycle, so hi and last line up with the registered count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
      r_hi   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_last <= run && (w_cnt_nxt == div - 1'b1);
      r_hi   <= run && (w_cnt_nxt < DIV_W'(high_time(32'(div))));
    end
  end
  assign cnt  = r_cnt;
  assign last = r_last;
  assign hi   = r_hi;
endmodule

// File: rtl/fre_div_ctrl.sv
// fre_div_ctrl: runtime-programmable clock divider with boundary-aligned ratio and enable changes
module fre_div_ctrl import fre_div_pkg::*; #(
  parameter int DIV_W   = 8,
  parameter int MAX_DIV = 255,
  parameter int RST_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_d,
  output logic             tick,
  output logic             busy
);
  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cur_div, r_pend_div, w_div_nxt, w_pend_nxt, w_cnt;
  logic             r_cfg_err, w_xfer, w_legal, w_ok, w_last, w_hi, w_unused_cnt;
  assign w_xfer  = cfg_valid && (r_state != PEND);
  assign w_legal = (cfg_div >= DIV_W'(MIN_DIV)) && (cfg_div <= DIV_W'(MAX_DIV));
  assign w_ok    = w_xfer && w_legal;
  // next state and ratio; w_last marks the final cycle of the current divided period
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_cur_div;
    w_pend_nxt  = r_pend_div;
    case (r_state)
      IDLE: begin
        if (w_ok) w_div_nxt = cfg_div;
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_ok) begin
          w_pend_nxt  = cfg_div;
          w_state_nxt = PEND;
        end else if (!en) w_state_nxt = w_last ? IDLE : DRAIN;
      end
      PEND: begin
        if (w_last) begin
          w_div_nxt   = r_pend_div;
          w_state_nxt = en ? RUN : IDLE;
        end
      end
      DRAIN: begin
        if (w_last) begin
          if (w_ok) w_div_nxt = cfg_div;
          w_state_nxt = en ? RUN : IDLE;
        end else if (w_ok) begin
          w_pend_nxt  = cfg_div;
          w_state_nxt = PEND;
        end else if (en) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // control registers; reset drops any pending ratio
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur_div  <= DIV_W'(RST_DIV);
      r_pend_div <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_div  <= w_div_nxt;
      r_pend_div <= w_pend_nxt;
      r_cfg_err  <= w_xfer && !w_legal;
    end
  end
  fre_div_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_state_nxt != IDLE),
    .div     (w_div_nxt),
    .restart (r_state == IDLE),
    .cnt     (w_cnt),
    .last    (w_last),
    .hi      (w_hi)
  );
  assign w_unused_cnt = ^w_cnt;
  assign cfg_ready    = (r_state != PEND);
  assign busy         = (r_state != IDLE);
  assign cfg_err      = r_cfg_err;
  assign cur_div      = r_cur_div;
  assign clk_d        = w_hi;
  assign tick         = w_last;
endmodule
